// File: rtl/picomips_ctrl_pkg.sv
// Shared encodings for the picoMIPS control unit: opcodes, FSM states, ALU function and select codes.
// ALU code values mirror alucodes.sv so the datapath and controller agree.
package picomips_ctrl_pkg;

    typedef enum logic [3:0] {
        OpNop   = 4'd0,
        OpAdd   = 4'd1,
        OpAddi  = 4'd2,
        OpSub   = 4'd3,
        OpSubi  = 4'd4,
        OpMull  = 4'd5,
        OpMulli = 4'd6,
        OpMov   = 4'd7,
        OpLdsw  = 4'd8,
        OpBeq   = 4'd9,
        OpBne   = 4'd10,
        OpJmp   = 4'd11,
        OpHalt  = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        StFetch,
        StExec,
        StSwhi,
        StSwlo,
        StHalt
    } state_e;

    typedef struct packed {
        logic v;
        logic n;
        logic z;
        logic c;
    } flags_t;

    localparam logic [2:0] RA    = 3'd0;
    localparam logic [2:0] RB    = 3'd1;
    localparam logic [2:0] RADD  = 3'd2;
    localparam logic [2:0] RSUB  = 3'd3;
    localparam logic [2:0] RMULL = 3'd4;

    localparam logic [1:0] REG    = 2'd0;
    localparam logic [1:0] SW_7_0 = 2'd1;
    localparam logic [1:0] SW_8   = 2'd2;

    // Only the arithmetic ops update the branch flags.
    function automatic logic is_flag_op(opcode_e op);
        return (op >= OpAdd) && (op <= OpMulli);
    endfunction

endpackage

// File: rtl/picomips_ctrl_if.sv
// Controller <-> datapath bundle: instruction/flags/switch in, ALU controls, register addresses and PC out.
interface picomips_ctrl_if #(
    parameter int unsigned N   = 8,
    parameter int unsigned RW  = 3,
    parameter int unsigned PCW = 6
);
    localparam int unsigned IW = 4 + 2 * RW + N;

    logic [IW-1:0]  instr;
    logic [3:0]     flags;
    logic           sw8;
    logic [PCW-1:0] pc;
    logic [2:0]     func;
    logic [1:0]     a_sel;
    logic [1:0]     b_sel;
    logic           imm;
    logic [N-1:0]   immediate;
    logic [RW-1:0]  ra_addr;
    logic [RW-1:0]  rb_addr;
    logic [RW-1:0]  wr_addr;
    logic           reg_we;
    logic           halted;

    modport master (
        input  instr, flags, sw8,
        output pc, func, a_sel, b_sel, imm, immediate, ra_addr, rb_addr, wr_addr, reg_we, halted
    );

    modport slave (
        output instr, flags, sw8,
        input  pc, func, a_sel, b_sel, imm, immediate, ra_addr, rb_addr, wr_addr, reg_we, halted
    );
endinterface

// File: rtl/picomips_ctrl_sync2.sv
// Two-flop synchronizer for an asynchronous level input.
module picomips_ctrl_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/picomips_ctrl.sv
// picoMIPS control unit: instruction decode, FETCH/EXEC sequencing, PC, branch flags and
// the switch-8 press/release handshake used by LDSW.
module picomips_ctrl
    import picomips_ctrl_pkg::*;
#(
    parameter int unsigned N   = 8,
    parameter int unsigned RW  = 3,
    parameter int unsigned PCW = 6
) (
    input  logic            clk,
    input  logic            reset,
    picomips_ctrl_if.master bus
);
    localparam int unsigned IW = 4 + 2 * RW + N;

    state_e         state_q;
    logic [PCW-1:0] pc_q;
    flags_t         flags_q;
    logic           sw8_s;

    opcode_e        op;
    logic [RW-1:0]  rd;
    logic [RW-1:0]  rs;
    logic [N-1:0]   k;

    logic [2:0]     dec_func;
    logic           dec_imm;
    logic           dec_we;
    logic [PCW-1:0] pc_inc;
    logic [PCW-1:0] pc_br;
    logic [PCW-1:0] pc_next;

    logic [2:0]     func;
    logic [1:0]     a_sel;
    logic           imm;
    logic           reg_we;

    picomips_ctrl_sync2 u_sync_sw8 (
        .clk   (clk),
        .reset (reset),
        .d     (bus.sw8),
        .q     (sw8_s)
    );

    assign op = opcode_e'(bus.instr[IW-1 -: 4]);
    assign rd = bus.instr[IW-5 -: RW];
    assign rs = bus.instr[IW-5-RW -: RW];
    assign k  = bus.instr[N-1:0];

    always_comb begin
        dec_func = RA;
        dec_imm  = 1'b0;
        dec_we   = 1'b0;
        case (op)
            OpAdd:   begin dec_func = RADD;  dec_we = 1'b1; end
            OpAddi:  begin dec_func = RADD;  dec_we = 1'b1; dec_imm = 1'b1; end
            OpSub:   begin dec_func = RSUB;  dec_we = 1'b1; end
            OpSubi:  begin dec_func = RSUB;  dec_we = 1'b1; dec_imm = 1'b1; end
            OpMull:  begin dec_func = RMULL; dec_we = 1'b1; end
            OpMulli: begin dec_func = RMULL; dec_we = 1'b1; dec_imm = 1'b1; end
            OpMov:   begin dec_func = RB;    dec_we = 1'b1; end
            default: ;
        endcase
    end

    // Offsets are two's complement; truncating k to PCW bits gives the wrap-around add.
    assign pc_inc = pc_q + PCW'(1);
    assign pc_br  = pc_q + k[PCW-1:0];

    always_comb begin
        pc_next = pc_inc;
        case (op)
            OpBeq:   pc_next = flags_q.z ? pc_br : pc_inc;
            OpBne:   pc_next = flags_q.z ? pc_inc : pc_br;
            OpJmp:   pc_next = k[PCW-1:0];
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= '0;
            flags_q <= '0;
        end else begin
            case (state_q)
                StFetch: state_q <= StExec;
                StExec: begin
                    if (is_flag_op(op)) begin
                        flags_q <= flags_t'(bus.flags);
                    end
                    case (op)
                        OpLdsw:  state_q <= StSwhi;
                        OpHalt:  state_q <= StHalt;
                        default: begin
                            state_q <= StFetch;
                            pc_q    <= pc_next;
                        end
                    endcase
                end
                StSwhi: if (sw8_s) state_q <= StSwlo;
                StSwlo: begin
                    if (!sw8_s) begin
                        state_q <= StFetch;
                        pc_q    <= pc_inc;
                    end
                end
                StHalt:  ;
                default: state_q <= StFetch;
            endcase
        end
    end

    // Controls depend only on state, instr and the synchronized switch, never on raw inputs.
    always_comb begin
        func   = RA;
        a_sel  = REG;
        imm    = 1'b0;
        reg_we = 1'b0;
        case (state_q)
            StExec: begin
                func   = dec_func;
                imm    = dec_imm;
                reg_we = dec_we;
            end
            StSwlo: begin
                if (!sw8_s) begin
                    a_sel  = SW_7_0;
                    reg_we = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.pc        = pc_q;
    assign bus.func      = func;
    assign bus.a_sel     = a_sel;
    assign bus.b_sel     = REG;
    assign bus.imm       = imm;
    assign bus.immediate = k;
    assign bus.ra_addr   = rd;
    assign bus.rb_addr   = rs;
    assign bus.wr_addr   = rd;
    assign bus.reg_we    = reg_we;
    assign bus.halted    = (state_q == StHalt);
endmodule

// File: tb/tb_picomips_ctrl.sv
// Bench for picomips_ctrl: sync ROM, register file and ALU model around the controller,
// a decode vector table plus directed branch, jump, LDSW handshake, HALT and reset sequences.
module tb_picomips_ctrl;
    import picomips_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    picomips_ctrl_if bus ();

    picomips_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [17:0] rom [64];
    logic [7:0]  regs [8];
    logic [7:0]  sw_val = 8'h5A;
    int          we_cnt;

    always @(posedge clk) bus.instr <= rom[bus.pc];

    logic [7:0]  alu_a, alu_b, alu_r;
    logic [8:0]  sum;
    logic [15:0] prod;
    logic        carry;

    always_comb begin
        alu_a = (bus.a_sel == SW_7_0) ? sw_val : regs[bus.ra_addr];
        alu_b = bus.imm ? bus.immediate : regs[bus.rb_addr];
        sum   = '0;
        prod  = 16'(alu_a) * 16'(alu_b);
        carry = 1'b0;
        alu_r = alu_a;
        case (bus.func)
            RA:    alu_r = alu_a;
            RB:    alu_r = alu_b;
            RADD:  begin sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_r = sum[7:0]; carry = sum[8]; end
            RSUB:  begin sum = {1'b0, alu_a} - {1'b0, alu_b}; alu_r = sum[7:0]; carry = sum[8]; end
            RMULL: alu_r = prod[7:0];
            default: ;
        endcase
        bus.flags = {1'b0, alu_r[7], (alu_r == 8'd0), carry};
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 8; r++) regs[r] <= 8'd0;
            we_cnt <= 0;
        end else if (bus.reg_we) begin
            regs[bus.wr_addr] <= alu_r;
            we_cnt <= we_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [17:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [7:0] k);
        return {op, rd, rs, k};
    endfunction

    task automatic clear_rom();
        for (int a = 0; a < 64; a++) rom[a] = mk(OpNop, 3'd0, 3'd0, 8'd0);
    endtask

    // Leaves reset released just after a negedge; the next posedge enters EXEC at pc 0.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.sw8 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [17:0] instr;
        logic [2:0]  func;
        logic [1:0]  a_sel;
        logic [1:0]  b_sel;
        logic        imm;
        logic        we;
        logic [5:0]  pc;
        logic        halt;
    } vec_t;

    vec_t vec [14];

    initial begin
        bus.sw8 = 1'b0;
        clear_rom();

        // Decode table, each from reset with flags_q = 0 (Z = 0).
        vec[0]  = '{mk(OpNop,   3'd1, 3'd2, 8'd5),   RA,    REG, REG, 1'b0, 1'b0, 6'd1,  1'b0};
        vec[1]  = '{mk(OpAdd,   3'd1, 3'd2, 8'd0),   RADD,  REG, REG, 1'b0, 1'b1, 6'd1,  1'b0};
        vec[2]  = '{mk(OpAddi,  3'd1, 3'd0, 8'd5),   RADD,  REG, REG, 1'b1, 1'b1, 6'd1,  1'b0};
        vec[3]  = '{mk(OpSub,   3'd1, 3'd2, 8'd0),   RSUB,  REG, REG, 1'b0, 1'b1, 6'd1,  1'b0};
        vec[4]  = '{mk(OpSubi,  3'd1, 3'd0, 8'd3),   RSUB,  REG, REG, 1'b1, 1'b1, 6'd1,  1'b0};
        vec[5]  = '{mk(OpMull,  3'd1, 3'd2, 8'd0),   RMULL, REG, REG, 1'b0, 1'b1, 6'd1,  1'b0};
        vec[6]  = '{mk(OpMulli, 3'd1, 3'd0, 8'd7),   RMULL, REG, REG, 1'b1, 1'b1, 6'd1,  1'b0};
        vec[7]  = '{mk(OpMov,   3'd1, 3'd2, 8'd0),   RB,    REG, REG, 1'b0, 1'b1, 6'd1,  1'b0};
        vec[8]  = '{mk(OpLdsw,  3'd1, 3'd0, 8'd0),   RA,    REG, REG, 1'b0, 1'b0, 6'd0,  1'b0};
        vec[9]  = '{mk(OpBeq,   3'd0, 3'd0, 8'd5),   RA,    REG, REG, 1'b0, 1'b0, 6'd1,  1'b0};
        vec[10] = '{mk(OpBne,   3'd0, 3'd0, 8'd5),   RA,    REG, REG, 1'b0, 1'b0, 6'd5,  1'b0};
        vec[11] = '{mk(OpJmp,   3'd0, 3'd0, 8'd40),  RA,    REG, REG, 1'b0, 1'b0, 6'd40, 1'b0};
        vec[12] = '{mk(4'd13,   3'd1, 3'd2, 8'd9),   RA,    REG, REG, 1'b0, 1'b0, 6'd1,  1'b0};
        vec[13] = '{mk(OpHalt,  3'd0, 3'd0, 8'd0),   RA,    REG, REG, 1'b0, 1'b0, 6'd0,  1'b1};

        do_reset();
        #1;
        check("reset pc", int'(bus.pc), 0);
        check("reset reg_we", int'(bus.reg_we), 0);
        check("reset halted", int'(bus.halted), 0);
        check("reset func", int'(bus.func), int'(RA));

        for (int i = 0; i < 14; i++) begin
            clear_rom();
            rom[0] = vec[i].instr;
            do_reset();
            step();
            check($sformatf("vec%0d func", i), int'(bus.func), int'(vec[i].func));
            check($sformatf("vec%0d a_sel", i), int'(bus.a_sel), int'(vec[i].a_sel));
            check($sformatf("vec%0d b_sel", i), int'(bus.b_sel), int'(vec[i].b_sel));
            check($sformatf("vec%0d imm", i), int'(bus.imm), int'(vec[i].imm));
            check($sformatf("vec%0d reg_we", i), int'(bus.reg_we), int'(vec[i].we));
            step();
            check($sformatf("vec%0d next pc", i), int'(bus.pc), int'(vec[i].pc));
            check($sformatf("vec%0d fetch reg_we", i), int'(bus.reg_we), 0);
            check($sformatf("vec%0d halted", i), int'(bus.halted), int'(vec[i].halt));
        end

        // Field extraction.
        clear_rom();
        rom[0] = mk(OpAddi, 3'd3, 3'd5, 8'hA7);
        do_reset();
        step();
        check("field immediate", int'(bus.immediate), 'hA7);
        check("field ra_addr", int'(bus.ra_addr), 3);
        check("field rb_addr", int'(bus.rb_addr), 5);
        check("field wr_addr", int'(bus.wr_addr), 3);

        // ADDI/SUBI then BEQ back-branch (Z=1), re-SUBI gives Z=0, BEQ falls through, BNE taken.
        begin
            int exp_pc [18] = '{0, 1, 1, 2, 2, 3, 3, 1, 1, 2, 2, 3, 3, 4, 4, 6, 6, 6};
            int exp_we [18] = '{1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
            int bad;
            clear_rom();
            rom[0] = mk(OpAddi, 3'd1, 3'd0, 8'd5);
            rom[1] = mk(OpSubi, 3'd1, 3'd0, 8'd5);
            rom[2] = mk(OpNop,  3'd0, 3'd0, 8'd0);
            rom[3] = mk(OpBeq,  3'd0, 3'd0, 8'hFE);
            rom[4] = mk(OpBne,  3'd0, 3'd0, 8'd2);
            rom[6] = mk(OpHalt, 3'd0, 3'd0, 8'd0);
            do_reset();
            for (int s = 0; s < 18; s++) begin
                step();
                check($sformatf("seq pc s%0d", s + 1), int'(bus.pc), exp_pc[s]);
                check($sformatf("seq reg_we s%0d", s + 1), int'(bus.reg_we), exp_we[s]);
            end
            check("seq write count", we_cnt, 3);
            check("seq r1 after re-SUBI", int'(regs[1]), 'hFB);
            check("seq halted", int'(bus.halted), 1);
            bad = 0;
            for (int c = 0; c < 100; c++) begin
                step();
                if (bus.pc != 6'd6 || bus.reg_we || !bus.halted) bad++;
            end
            check("halt 100 cycles bad", bad, 0);
            @(negedge clk);
            reset = 1'b1;
            #1;
            check("halt reset pc", int'(bus.pc), 0);
            check("halt reset halted", int'(bus.halted), 0);
            check("halt reset reg_we", int'(bus.reg_we), 0);
        end

        // JMP 63 then NOP wraps to 0.
        clear_rom();
        rom[0] = mk(OpJmp, 3'd0, 3'd0, 8'd63);
        do_reset();
        step();
        step();
        check("jmp pc", int'(bus.pc), 63);
        step();
        step();
        check("wrap pc", int'(bus.pc), 0);

        // LDSW with a 5-cycle press.
        begin
            bit seen = 1'b0;
            int delay = 0;
            int seen_asel = 0;
            int seen_func = 0;
            clear_rom();
            rom[0] = mk(OpLdsw, 3'd2, 3'd0, 8'd0);
            rom[1] = mk(OpHalt, 3'd0, 3'd0, 8'd0);
            do_reset();
            repeat (4) step();
            check("ldsw idle writes", we_cnt, 0);
            @(negedge clk);
            bus.sw8 = 1'b1;
            repeat (5) @(negedge clk);
            check("ldsw press writes", we_cnt, 0);
            bus.sw8 = 1'b0;
            for (int t = 1; t <= 10; t++) begin
                step();
                if (!seen && bus.reg_we) begin
                    seen = 1'b1;
                    delay = t;
                    seen_asel = int'(bus.a_sel);
                    seen_func = int'(bus.func);
                end
                if (t == 4) check("ldsw pc after", int'(bus.pc), 1);
            end
            check("ldsw write seen", int'(seen), 1);
            check("ldsw delay in 2..3", int'(delay >= 2 && delay <= 3), 1);
            check("ldsw a_sel", seen_asel, int'(SW_7_0));
            check("ldsw func", seen_func, int'(RA));
            check("ldsw write count", we_cnt, 1);
            check("ldsw r2", int'(regs[2]), 'h5A);
        end

        // Reset while waiting in SWHI with the switch pressed.
        clear_rom();
        rom[0] = mk(OpLdsw, 3'd3, 3'd0, 8'd0);
        rom[1] = mk(OpHalt, 3'd0, 3'd0, 8'd0);
        do_reset();
        step();
        step();
        @(negedge clk);
        bus.sw8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midswhi pc", int'(bus.pc), 0);
        check("midswhi reg_we", int'(bus.reg_we), 0);
        check("midswhi state", int'(dut.state_q), int'(StFetch));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) step();
        check("midswhi held writes", we_cnt, 0);
        check("midswhi held pc", int'(bus.pc), 0);
        @(negedge clk);
        bus.sw8 = 1'b0;
        repeat (4) step();
        check("midswhi release writes", we_cnt, 1);
        check("midswhi r3", int'(regs[3]), 'h5A);
        check("midswhi pc after", int'(bus.pc), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
